uart_receiver: RTL
==================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter D_BITS, default 8: data bits per frame.
REQ-002 Parameter SP_BITS, default 1: stop bits per frame (1 or 2).
REQ-003 Parameter OVERSAMPLE, default 16: i_s_tick pulses per bit period, even, >=8.
REQ-004 i_clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 i_rx  input  1  serial line, asynchronous to i_clk, idle high.
REQ-007 i_s_tick  input  1  one-cycle oversample strobe from the baud generator.
REQ-008 i_rx_ack  input  1  consumer acknowledge of the held word.
REQ-009 o_br_rst  output  1  baud-generator reset; realigns tick phase to start edge.
REQ-010 o_data  output  D_BITS  last received word, LSB first on the line.
REQ-011 o_rx_valid  output  1  o_data holds an unacknowledged word.
REQ-012 o_rx_done  output  1  one-cycle pulse at frame completion.
REQ-013 o_frame_err  output  1  last frame's stop bit sampled low.
REQ-014 o_overrun  output  1  a word was overwritten before acknowledgement.

Function
REQ-015 i_rx passes through a 2-flop synchronizer; all decisions use the synchronized value, giving 2 cycles of input latency.
REQ-016 States: IDLE, START, DATA, PARITY (macro only), STOP; tick counter is $clog2(OVERSAMPLE) bits, bit counter $clog2(D_BITS)+1 bits.
REQ-017 IDLE: o_br_rst=1; a 1->0 transition on the synchronized line clears the tick counter, sets o_br_rst=0, and moves to START.
REQ-018 START: on tick number OVERSAMPLE/2-1 (mid-bit) the line is sampled; 0 -> DATA with counters cleared, 1 -> false start, back to IDLE, nothing reported.
REQ-019 DATA: on each OVERSAMPLE-th tick the line is shifted in at the MSB of the shift register (right shift); after D_BITS samples -> PARITY or STOP.
REQ-020 STOP: samples are taken every OVERSAMPLE ticks; after SP_BITS samples -> IDLE; a low sample in any stop bit sets the frame error.
REQ-021 At frame completion, in a single cycle: o_data <= shift register, o_rx_done=1 for exactly one cycle, o_rx_valid <= 1, o_frame_err <= stop result.
REQ-022 A frame with a framing error is still delivered (valid and done assert) with o_frame_err=1.
REQ-023 i_rx_ack with o_rx_valid=1 clears o_rx_valid and o_overrun on the next edge; an ack with o_rx_valid=0 is ignored.
REQ-024 Completion while o_rx_valid=1 and no ack: o_data is overwritten, o_overrun <= 1 and held until ack.
REQ-025 Completion and ack in the same cycle: o_rx_valid stays 1 with the new word, o_overrun is not set.
REQ-026 The receiver returns to IDLE at the middle of the final stop bit, so back-to-back frames are accepted.
REQ-027 An illegal state encoding goes to IDLE on the next edge.

Reset
REQ-028 reset low asynchronously forces: state IDLE, synchronizer flops 1, counters 0, o_data 0, o_rx_valid 0, o_rx_done 0, o_frame_err 0, o_overrun 0, o_br_rst 1.
REQ-029 Reset asserted mid-frame abandons the frame and reports nothing; after release, reception starts only on a new falling edge.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: after DATA, one PARITY bit is sampled mid-bit and checked for even parity over data plus parity; output o_parity_err (1 bit) is updated at completion like o_frame_err and is reset to 0.
REQ-031 Macro undefined: there is no PARITY state and no o_parity_err port; the STOP state follows DATA directly.

Verification
REQ-032 Frame 0xA5 with 1 stop bit, at 16 ticks/bit -> o_data=0xA5, one o_rx_done pulse, o_rx_valid=1, o_frame_err=0.
REQ-033 0x3C received with the stop bit driven low -> o_data=0x3C, o_frame_err=1, o_rx_valid=1.
REQ-034 A 4-tick low glitch on an idle line -> returns to IDLE, no o_rx_done, all outputs unchanged.
REQ-035 Frames 0x11 then 0x22 with no ack -> o_data=0x22, o_overrun=1; then ack -> o_rx_valid=0, o_overrun=0.
REQ-036 reset driven low at data bit 4 of 0xFF, then a full frame 0x5A -> only 0x5A is delivered, no error flags.
REQ-037 With UART_RX_PARITY_EN, 0x07 with parity bit 0 -> o_parity_err=1; with parity bit 1 -> o_parity_err=0.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled asynchronous serial receiver.
// Line is synchronized, start edge detected, bits sampled mid-bit
// (OVERSAMPLE ticks per bit), and each completed word is held in o_data
// with valid/overrun handshake and framing status.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit after
// the data bits and an o_parity_err output.
module uart_receiver #(
    parameter int D_BITS     = 8,
    parameter int SP_BITS    = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic              i_rx,
    input  logic              i_s_tick,
    input  logic              i_rx_ack,
    output logic              o_br_rst,
    output logic [D_BITS-1:0] o_data,
    output logic              o_rx_valid,
    output logic              o_rx_done,
    output logic              o_frame_err,
    output logic              o_overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic              o_parity_err
`endif
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(D_BITS) + 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(D_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(SP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    state_t            state;
    logic              rx_meta, rx_sync, rx_prev;
    logic [TW-1:0]     tick_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [D_BITS-1:0] shreg;
    logic              stop_err;
`ifdef UART_RX_PARITY_EN
    logic              par_err;
`endif

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Frame FSM with registered outputs and the consumer handshake
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            stop_err    <= 1'b0;
            o_br_rst    <= 1'b1;
            o_data      <= '0;
            o_rx_valid  <= 1'b0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err      <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            o_rx_done <= 1'b0;
            // Ack only matters while a word is held; completion below overrides
            if (i_rx_ack && o_rx_valid) begin
                o_rx_valid <= 1'b0;
                o_overrun  <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    o_br_rst <= 1'b1;
                    if (rx_prev && !rx_sync) begin
                        tick_cnt <= '0;
                        o_br_rst <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (i_s_tick) begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            if (!rx_sync) begin
                                state <= S_DATA;
                            end else begin
                                // Glitch, not a start bit
                                state    <= S_IDLE;
                                o_br_rst <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (i_s_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_sync, shreg[D_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt  <= '0;
                                stop_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                                state    <= S_PARITY;
`else
                                state    <= S_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (i_s_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            // Even parity: data plus parity bit must XOR to 0
                            par_err  <= ^{shreg, rx_sync};
                            state    <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (i_s_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (bit_cnt == STOP_LAST) begin
                                // Complete at mid final stop bit so the next start edge is caught
                                bit_cnt     <= '0;
                                o_data      <= shreg;
                                o_rx_done   <= 1'b1;
                                o_rx_valid  <= 1'b1;
                                o_overrun   <= o_rx_valid && !i_rx_ack;
                                o_frame_err <= stop_err | ~rx_sync;
`ifdef UART_RX_PARITY_EN
                                o_parity_err <= par_err;
`endif
                                state       <= S_IDLE;
                                o_br_rst    <= 1'b1;
                            end else begin
                                stop_err <= stop_err | ~rx_sync;
                                bit_cnt  <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    o_br_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule
